// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory port: fetch (0) and load/store (1).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 1 wins ties.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic cand0, cand1, win1;

  // A requester being acked this cycle may still show valid; it is not a new request.
  assign cand0 = req0_valid & ~ack0_q;
  assign cand1 = req1_valid & ~ack1_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  assign win1 = cand1 & (~cand0 | ~last_grant_q);
`else
  assign win1 = cand1;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cand0 | cand1) begin
          state_d = ST_GRANT;
          sel_d   = win1;
          valid_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = win1;
`endif
        end
      end
      ST_GRANT, ST_ACCESS: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          rdata_d = mem_rdata;
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Port mux follows the latched select; requester 0 never writes.
  assign mem_addr  = sel_q ? req1_addr : req0_addr;
  assign mem_we    = sel_q & req1_we;
  assign mem_wdata = sel_q ? req1_wdata : '0;

  assign mem_valid = valid_q;
  assign busy      = valid_q;
  assign mem_sel   = sel_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req1_we, mem_ready;
  logic [31:0] req0_addr, req1_addr, req1_wdata, mem_rdata;
  logic        mem_valid, mem_sel, mem_we, ack0, ack1, busy;
  logic [31:0] mem_addr, mem_wdata, rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_wdata(req1_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: which requester owns the port (-1 = none), and this cycle's ack.
  int          m_owner;
  bit          m_ack0, m_ack1, m_sel, m_last;
  logic [31:0] m_rdata;

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ack0  = 1'b0;
    m_ack1  = 1'b0;
    m_sel   = 1'b0;
    m_last  = 1'b1;
    m_rdata = 32'h0;
  endtask

  // One clock edge of the transaction rules, applied to the inputs the edge samples.
  task automatic model_edge();
    bit c0, c1;
    int w;
    if (m_owner >= 0) begin
      m_ack0 = 1'b0;
      m_ack1 = 1'b0;
      if (mem_ready) begin
        if (m_owner == 0) m_ack0 = 1'b1;
        else              m_ack1 = 1'b1;
        m_rdata = mem_rdata;
        m_owner = -1;
      end
    end else begin
      c0 = req0_valid && !m_ack0;
      c1 = req1_valid && !m_ack1;
      m_ack0 = 1'b0;
      m_ack1 = 1'b0;
      if (c0 || c1) begin
        if (c0 && c1) w = RR ? (m_last ? 0 : 1) : 1;
        else          w = c1 ? 1 : 0;
        m_owner = w;
        m_sel   = (w == 1);
        m_last  = (w == 1);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    chk1("mem_valid", mem_valid, m_owner >= 0);
    chk1("busy", busy, m_owner >= 0);
    chk1("mem_sel", mem_sel, m_sel);
    chk1("ack0", ack0, m_ack0);
    chk1("ack1", ack1, m_ack1);
    chk32("mem_addr", mem_addr, m_sel ? req1_addr : req0_addr);
    chk1("mem_we", mem_we, m_sel & req1_we);
    chk32("mem_wdata", mem_wdata, m_sel ? req1_wdata : 32'h0);
    if (m_ack0 || m_ack1) chk32("rdata", rdata, m_rdata);
  endtask

  bit g[8];
  int n_g;
  bit prev_v;
  bit done0, done1;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = 32'h0;
    req1_valid = 1'b0; req1_addr = 32'h0; req1_we = 1'b0; req1_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    model_reset();

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_valid", mem_valid, 1'b0);
    chk1("rst_mem_sel", mem_sel, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk32("rst_rdata", rdata, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Single fetch, memory ready on the first access cycle
    cyc(); req0_valid = 1'b1; req0_addr = 32'h0000_0010; mem_ready = 1'b1; mem_rdata = 32'h0050_0113;
    sample();
    cyc(); sample();
    chk1("t1_valid", mem_valid, 1'b1);
    chk1("t1_sel", mem_sel, 1'b0);
    chk32("t1_addr", mem_addr, 32'h0000_0010);
    cyc(); req0_valid = 1'b0; sample();
    chk1("t1_ack0", ack0, 1'b1);
    chk32("t1_rdata", rdata, 32'h0050_0113);
    chk1("t1_valid_off", mem_valid, 1'b0);
    cyc(); sample();
    chk1("t1_ack0_pulse", ack0, 1'b0);

    // Store with three wait cycles
    cyc(); req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h0000_1000; req1_wdata = 32'hDEAD_BEEF;
    mem_ready = 1'b0; sample();
    for (int i = 0; i < 4; i++) begin
      cyc(); if (i == 3) mem_ready = 1'b1; sample();
      chk1("t2_valid", mem_valid, 1'b1);
      chk1("t2_sel", mem_sel, 1'b1);
      chk1("t2_we", mem_we, 1'b1);
      chk32("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk1("t2_no_ack1", ack1, 1'b0);
      chk1("t2_no_ack0", ack0, 1'b0);
    end
    cyc(); req1_valid = 1'b0; mem_ready = 1'b0; sample();
    chk1("t2_ack1", ack1, 1'b1);
    chk1("t2_ack0_never", ack0, 1'b0);
    cyc(); sample();
    chk1("t2_ack1_pulse", ack1, 1'b0);

    // Both requesters held; each drops only on its ack once four grants were seen
    cyc(); req0_valid = 1'b1; req0_addr = 32'h0000_0040; req1_valid = 1'b1; req1_we = 1'b0;
    req1_addr = 32'h0000_2000; mem_ready = 1'b1; sample();
    n_g = 0; prev_v = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      mem_rdata = $urandom;
      if (n_g >= 4) begin
        if (m_ack0) req0_valid = 1'b0;
        if (m_ack1) req1_valid = 1'b0;
      end
      sample();
      if (mem_valid && !prev_v && n_g < 8) begin g[n_g] = mem_sel; n_g++; end
      prev_v = mem_valid;
    end
    chk32("t3_grants", 32'(n_g), 32'd5);
    // The acked requester is ignored on its ack cycle, so the other one takes the next grant.
    for (int i = 0; i < 4; i++)
      chk1("t3_grant_seq", g[i], RR ? (i % 2 == 1) : (i % 2 == 0));

    // mem_sel stays put while busy even though requester 1 rises mid-access
    cyc(); req0_valid = 1'b1; req0_addr = 32'h0000_0200; mem_ready = 1'b0; sample();
    cyc(); sample();
    chk1("t4_sel_grant", mem_sel, 1'b0);
    cyc(); req1_valid = 1'b1; req1_addr = 32'h0000_0300; req1_we = 1'b0; sample();
    for (int i = 0; i < 4; i++) begin
      cyc(); if (i == 3) mem_ready = 1'b1; sample();
      chk1("t4_busy", busy, 1'b1);
      chk1("t4_sel_stable", mem_sel, 1'b0);
    end
    cyc(); req0_valid = 1'b0; mem_ready = 1'b0; sample();
    chk1("t4_ack0", ack0, 1'b1);
    cyc(); sample();
    chk1("t4_regrant_sel", mem_sel, 1'b1);
    cyc(); mem_ready = 1'b1; sample();
    cyc(); req1_valid = 1'b0; mem_ready = 1'b0; sample();
    chk1("t4_ack1", ack1, 1'b1);

    // Idle cycles hold the last select
    for (int i = 0; i < 3; i++) begin
      cyc(); sample();
      chk1("t6_idle_valid", mem_valid, 1'b0);
      chk1("t6_idle_busy", busy, 1'b0);
      chk1("t6_sel_hold", mem_sel, 1'b1);
    end

    // Reset during an access abandons it
    cyc(); req0_valid = 1'b1; req0_addr = 32'h0000_0400; mem_ready = 1'b0; sample();
    cyc(); sample();
    cyc(); sample();
    chk1("t5_in_access", mem_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t5_valid_drop", mem_valid, 1'b0);
    chk1("t5_busy_drop", busy, 1'b0);
    chk1("t5_no_ack0", ack0, 1'b0);
    model_reset();
    @(posedge clk);
    sample();
    rst_n = 1'b1;
    cyc(); mem_ready = 1'b1; sample();
    chk1("t5_regrant", mem_valid, 1'b1);
    chk32("t5_addr", mem_addr, 32'h0000_0400);
    cyc(); req0_valid = 1'b0; mem_ready = 1'b0; sample();
    chk1("t5_ack0", ack0, 1'b1);

    // Random traffic
    done0 = 1'b0; done1 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      if (m_ack0) begin
        done0 = 1'b1;
        if ($urandom_range(0, 1) == 1) req0_valid = 1'b0;
      end else begin
        if (done0) begin req0_valid = 1'b0; done0 = 1'b0; end
        if (!req0_valid && $urandom_range(0, 99) < 40) begin
          req0_valid = 1'b1; req0_addr = $urandom;
        end
      end
      if (m_ack1) begin
        done1 = 1'b1;
        if ($urandom_range(0, 1) == 1) req1_valid = 1'b0;
      end else begin
        if (done1) begin req1_valid = 1'b0; done1 = 1'b0; end
        if (!req1_valid && $urandom_range(0, 99) < 40) begin
          req1_valid = 1'b1; req1_addr = $urandom; req1_we = 1'($urandom_range(0, 1));
          req1_wdata = $urandom;
        end
      end
      sample();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
